shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with increment-entered operands.
// Optional two's-complement mode multiplies magnitudes and fixes the sign at the end.
module shift_add_multiplier #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 inc,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   res_fin;
  logic [WIDTH:0]       res_top;
  logic                 ovf_calc;

  // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
  always_comb begin
    mag_a    = (SIGNED && op_a_q[WIDTH-1]) ? (~op_a_q + 1'b1) : op_a_q;
    mag_b    = (SIGNED && op_b_q[WIDTH-1]) ? (~op_b_q + 1'b1) : op_b_q;
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    res_fin  = (SIGNED && neg_q) ? (~{acc_q, mplier_q} + 1'b1) : {acc_q, mplier_q};
    res_top  = res_fin[2*WIDTH-1:WIDTH-1];
    ovf_calc = SIGNED ? !((res_top == '0) || (res_top == '1))
                      : (res_fin[2*WIDTH-1:WIDTH] != '0);
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          done_d  = 1'b0;
        end else if (inc) begin
          done_d = 1'b0;
          if (sel) op_b_d = op_b_q + 1'b1;
          else     op_a_d = op_a_q + 1'b1;
        end
      end
      StLoad: begin
        mcand_d  = mag_a;
        mplier_d = mag_b;
        acc_d    = '0;
        cnt_d    = '0;
        neg_d    = SIGNED && (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
        state_d  = StRun;
      end
      StRun: begin
        // Carry drops into acc MSB; acc LSB shifts into the multiplier register.
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1)) state_d = StFin;
      end
      StFin: begin
        product_d = res_fin;
        ovf_d     = ovf_calc;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign product = product_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: unsigned and signed instances share stimulus and
// are checked against integer-arithmetic reference products.
module tb_shift_add_multiplier;
  localparam int unsigned W = 8;

  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, inc = 1'b0, start = 1'b0;
  logic [W-1:0]   a_u, b_u, a_s, b_s;
  logic [2*W-1:0] p_u, p_s;
  logic busy_u, done_u, ovf_u, busy_s, done_s, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  logic [W-1:0] a_m = '0, b_m = '0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .sel(sel), .inc(inc), .start(start),
    .op_a(a_u), .op_b(b_u), .product(p_u), .busy(busy_u), .done(done_u), .ovf(ovf_u)
  );

  shift_add_multiplier #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .sel(sel), .inc(inc), .start(start),
    .op_a(a_s), .op_b(b_s), .product(p_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic int ref_val(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    return sgn ? sval(a) * sval(b) : int'(a) * int'(b);
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input bit sgn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int v;
    v = ref_val(sgn, a, b);
    return v[2*W-1:0];
  endfunction

  function automatic logic ref_ovf(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int v;
    v = ref_val(sgn, a, b);
    if (sgn) return (v < -(1 << (W - 1))) || (v > (1 << (W - 1)) - 1);
    return v > (1 << W) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input logic s);
    sel = s;
    inc = 1'b1;
    tick();
    inc = 1'b0;
    if (s) b_m = b_m + 1'b1;
    else   a_m = a_m + 1'b1;
  endtask

  task automatic set_ops(input logic [W-1:0] ta, input logic [W-1:0] tb);
    logic [W-1:0] da, db;
    da = ta - a_m;
    db = tb - b_m;
    for (int i = 0; i < int'(da); i++) pulse_inc(1'b0);
    for (int i = 0; i < int'(db); i++) pulse_inc(1'b1);
  endtask

  task automatic run_op();
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_u; i++) begin
      busy_cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    a_m = '0;
    b_m = '0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if ({a_u, b_u, p_u} !== '0) begin n_fail++;
      $display("FAIL reset_regs_u: got %h %h %h want 0", a_u, b_u, p_u); end
    n_checks++; if ({busy_u, done_u, ovf_u, busy_s, done_s, ovf_s} !== 6'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b%b%b %b%b%b want 0", busy_u, done_u, ovf_u,
               busy_s, done_s, ovf_s); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    repeat (3) pulse_inc(1'b0);
    repeat (5) pulse_inc(1'b1);
    n_checks++; if (a_u !== 8'h03 || b_u !== 8'h05) begin n_fail++;
      $display("FAIL basic_ops: got %h %h want 03 05", a_u, b_u); end
    run_op();
    n_checks++; if (busy_cnt !== W + 2) begin n_fail++;
      $display("FAIL basic_busy_len: got %0d want %0d", busy_cnt, W + 2); end
    n_checks++; if (p_u !== 16'h000F || p_s !== 16'h000F) begin n_fail++;
      $display("FAIL basic_prod: got %h %h want 000f", p_u, p_s); end
    n_checks++; if (done_u !== 1'b1 || ovf_u !== 1'b0) begin n_fail++;
      $display("FAIL basic_flags: got done=%b ovf=%b want 1 0", done_u, ovf_u); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (255) pulse_inc(1'b0);
    repeat (255) pulse_inc(1'b1);
    n_checks++; if (a_u !== 8'hFF || b_u !== 8'hFF) begin n_fail++;
      $display("FAIL wrap_ff: got %h %h want ff ff", a_u, b_u); end
    pulse_inc(1'b0);
    n_checks++; if (a_u !== 8'h00) begin n_fail++;
      $display("FAIL wrap_zero: got %h want 00", a_u); end
    repeat (255) pulse_inc(1'b0);
    run_op();
    n_checks++; if (p_u !== 16'hFE01 || ovf_u !== 1'b1) begin n_fail++;
      $display("FAIL wrap_prod_u: got %h ovf=%b want fe01 1", p_u, ovf_u); end
    n_checks++; if (p_s !== 16'h0001 || ovf_s !== 1'b0) begin n_fail++;
      $display("FAIL wrap_prod_s: got %h ovf=%b want 0001 0", p_s, ovf_s); end
    n_checks++; if (a_u !== 8'hFF || b_u !== 8'hFF) begin n_fail++;
      $display("FAIL wrap_retain: got %h %h want ff ff", a_u, b_u); end
  endtask

  task automatic test_signed();
    set_ops(8'hFD, 8'h05);
    run_op();
    n_checks++; if (p_s !== 16'hFFF1 || ovf_s !== 1'b0) begin n_fail++;
      $display("FAIL signed_neg3x5: got %h ovf=%b want fff1 0", p_s, ovf_s); end
    n_checks++; if (p_u !== ref_prod(0, a_m, b_m) || ovf_u !== ref_ovf(0, a_m, b_m)) begin
      n_fail++; $display("FAIL signed_253x5_u: got %h ovf=%b want %h %b", p_u, ovf_u,
                         ref_prod(0, a_m, b_m), ref_ovf(0, a_m, b_m)); end
    set_ops(8'h80, 8'h80);
    run_op();
    n_checks++; if (p_s !== 16'h4000 || ovf_s !== 1'b1) begin n_fail++;
      $display("FAIL signed_minmin: got %h ovf=%b want 4000 1", p_s, ovf_s); end
    n_checks++; if (p_u !== 16'h4000 || ovf_u !== 1'b1) begin n_fail++;
      $display("FAIL unsigned_80x80: got %h ovf=%b want 4000 1", p_u, ovf_u); end
  endtask

  task automatic test_done_hold();
    n_checks++; if (done_s !== 1'b1) begin n_fail++;
      $display("FAIL done_held: got %b want 1", done_s); end
    pulse_inc(1'b1);
    n_checks++; if (done_s !== 1'b0 || done_u !== 1'b0) begin n_fail++;
      $display("FAIL done_clear_inc: got %b %b want 0 0", done_s, done_u); end
    n_checks++; if (p_s !== 16'h4000 || ovf_s !== 1'b1 || b_s !== 8'h81) begin n_fail++;
      $display("FAIL hold_after_inc: got %h %b %h want 4000 1 81", p_s, ovf_s, b_s); end
  endtask

  task automatic test_collision();
    set_ops(8'h1C, 8'h2B);
    sel   = 1'b0;
    start = 1'b1;
    inc   = 1'b1;
    tick();
    start = 1'b0;
    inc   = 1'b0;
    n_checks++; if (a_u !== a_m || busy_u !== 1'b1) begin n_fail++;
      $display("FAIL coll_start_inc: got a=%h busy=%b want %h 1", a_u, busy_u, a_m); end
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_u; i++) begin
      busy_cnt++;
      sel   = i[1];
      inc   = (i % 2 == 0);
      start = (i % 3 == 1);
      tick();
    end
    inc   = 1'b0;
    start = 1'b0;
    n_checks++; if (busy_cnt !== W + 2) begin n_fail++;
      $display("FAIL coll_busy_len: got %0d want %0d", busy_cnt, W + 2); end
    n_checks++; if (a_u !== a_m || b_u !== b_m) begin n_fail++;
      $display("FAIL coll_ops: got %h %h want %h %h", a_u, b_u, a_m, b_m); end
    n_checks++; if (p_u !== ref_prod(0, a_m, b_m) || done_u !== 1'b1) begin n_fail++;
      $display("FAIL coll_prod: got %h done=%b want %h 1", p_u, done_u, ref_prod(0, a_m, b_m));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      set_ops(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      run_op();
      n_checks++; if (p_u !== ref_prod(0, a_m, b_m) || ovf_u !== ref_ovf(0, a_m, b_m)) begin
        n_fail++; $display("FAIL rand_u %h*%h: got %h ovf=%b want %h %b", a_m, b_m, p_u, ovf_u,
                           ref_prod(0, a_m, b_m), ref_ovf(0, a_m, b_m)); end
      n_checks++; if (p_s !== ref_prod(1, a_m, b_m) || ovf_s !== ref_ovf(1, a_m, b_m)) begin
        n_fail++; $display("FAIL rand_s %h*%h: got %h ovf=%b want %h %b", a_m, b_m, p_s, ovf_s,
                           ref_prod(1, a_m, b_m), ref_ovf(1, a_m, b_m)); end
      n_checks++; if (done_s !== 1'b1 || busy_cnt !== W + 2) begin n_fail++;
        $display("FAIL rand_done: got done=%b busy_len=%0d want 1 %0d", done_s, busy_cnt, W + 2);
      end
    end
  endtask

  task automatic test_reset_midop();
    set_ops(8'h37, 8'h59);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++; if (busy_u !== 1'b1) begin n_fail++;
      $display("FAIL midop_busy: got %b want 1", busy_u); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if ({busy_u, done_u, busy_s, done_s} !== 4'b0) begin n_fail++;
      $display("FAIL midop_flags: got %b%b %b%b want 0", busy_u, done_u, busy_s, done_s); end
    n_checks++; if ({p_u, p_s, a_u, b_u, ovf_u, ovf_s} !== '0) begin n_fail++;
      $display("FAIL midop_regs: got %h %h %h %h %b%b want 0", p_u, p_s, a_u, b_u,
               ovf_u, ovf_s); end
    @(negedge clk);
    reset = 1'b1;
    a_m = '0;
    b_m = '0;
    run_op();
    n_checks++; if (p_u !== 16'h0000 || done_u !== 1'b1 || busy_cnt !== W + 2) begin n_fail++;
      $display("FAIL midop_rerun: got %h done=%b busy_len=%0d want 0000 1 %0d", p_u, done_u,
               busy_cnt, W + 2); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_signed();
    test_done_hold();
    test_collision();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
